sr_mul_iter: RTL and testbench

Iterative multi-cycle unsigned multiplier for the schoolRISCV single-cycle CPU. It sits directly downstream of the control unit's multiply stall logic and consumes the same latency parameter N. The control unit holds the PC for N cycles on a `mul`, and this block delivers the low 32 bits of `srcA * srcB` in the last of those cycles, in time for the register-file write.

---
 rtl/sr_mul_pkg.sv | 34 +++
 rtl/sr_mul_slice.sv | 36 +++
 rtl/sr_mul_iter.sv | 200 ++++++++++++++++++++
 tb/tb_sr_mul_iter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_mul_pkg.sv
// -----------------------------------------------------------------------------
// sr_mul_pkg
//   Shared types and constants for the iterative multiplier (sr_mul_iter).
//
//   Contents:
//     sr_mul_state_t  - FSM state encoding (IDLE, RUN)
//     SR_MUL_W        - accumulator width: 32 bits, or 64 bits when the
//                       SR_MUL_MULHU_EN macro is defined (MULHU support)
//     sr_mul_n_ok()   - true when a latency N is one of 1,2,4,8,16,32
//
//   Configuration macro: SR_MUL_MULHU_EN
// -----------------------------------------------------------------------------
package sr_mul_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sr_mul_state_t;

`ifdef SR_MUL_MULHU_EN
  // The upper product word is needed, so the full 64-bit product is kept.
  localparam int SR_MUL_W = 64;
`else
  localparam int SR_MUL_W = 32;
`endif

  // N must divide 32 evenly and be a power of two so that every cycle
  // consumes an equal, aligned K-bit slice of the multiplier.
  function automatic bit sr_mul_n_ok(input int n);
    return (n == 1) || (n == 2) || (n == 4) ||
           (n == 8) || (n == 16) || (n == 32);
  endfunction

endpackage : sr_mul_pkg

// File: rtl/sr_mul_slice.sv
// -----------------------------------------------------------------------------
// sr_mul_slice
//   Combinational partial-product generator for one K-bit multiplier slice:
//     pp = (a * b_slice) << shift, truncated to SR_MUL_W bits.
//   One instance is shared by the start cycle (slice 0, shift 0) and by every
//   RUN cycle (slice 'step', shift step*K).
//
//   Parameters:
//     K        - slice width in bits (32 / N)
//   Ports:
//     a        in  [31:0]          multiplicand
//     b_slice  in  [K-1:0]         current multiplier slice
//     shift    in  [5:0]           left shift applied to the product
//     pp       out [SR_MUL_W-1:0]  shifted partial product
//
//   Configuration macro: SR_MUL_MULHU_EN (via SR_MUL_W in sr_mul_pkg)
// -----------------------------------------------------------------------------
module sr_mul_slice
  import sr_mul_pkg::*;
#(
  parameter int K = 8
) (
  input  logic [31:0]         a,
  input  logic [K-1:0]        b_slice,
  input  logic [5:0]          shift,
  output logic [SR_MUL_W-1:0] pp
);

  logic [SR_MUL_W-1:0] prod;

  // A 32 x K product never exceeds 64 bits, so in the 64-bit build nothing
  // is lost; in the 32-bit build the truncation is the intended modulo 2^32.
  assign prod = SR_MUL_W'(a) * SR_MUL_W'(b_slice);
  assign pp   = prod << shift;

endmodule : sr_mul_slice

// File: rtl/sr_mul_iter.sv
// -----------------------------------------------------------------------------
// sr_mul_iter
//   Iterative unsigned multiplier for the schoolRISCV single-cycle CPU.
//   Processes K = 32/N multiplier bits per cycle and presents the product in
//   cycle N-1 after the start cycle (cycle 0), the same cycle in which the
//   control unit releases its stall and commits the register write.
//
//   Parameters:
//     N       - latency in cycles; one of 1, 2, 4, 8, 16, 32 (default 4)
//   Ports:
//     clk     in        clock, rising edge
//     rst     in        asynchronous, active-low reset
//     start   in        MUL decoded this cycle (ignored unless IDLE)
//     srcA    in  [31:0] multiplicand, sampled at start
//     srcB    in  [31:0] multiplier, sampled at start
//     hi      in        (SR_MUL_MULHU_EN only) return product bits [63:32]
//     busy    out       operation in flight after its start cycle
//     done    out       result valid this cycle (single-cycle pulse)
//     result  out [31:0] product word; 0 whenever done is low
//
//   Configuration macro: SR_MUL_MULHU_EN adds the 'hi' input and widens the
//   accumulator to 64 bits; latency and handshake are unchanged.
// -----------------------------------------------------------------------------
module sr_mul_iter
  import sr_mul_pkg::*;
#(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
`ifdef SR_MUL_MULHU_EN
  input  logic        hi,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int K  = 32 / N;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int W  = SR_MUL_W;
  localparam logic [SW-1:0] STEP_LAST = SW'(N - 1);

  if (!sr_mul_n_ok(N)) begin : g_bad_n
    $error("sr_mul_iter: N=%0d is illegal; use 1, 2, 4, 8, 16 or 32", N);
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  sr_mul_state_t   state_q, state_d;
  logic [SW-1:0]   step_q,  step_d;
  logic [31:0]     a_q,     a_d;
  logic [31:0]     b_q,     b_d;
  logic [W-1:0]    acc_q,   acc_d;
`ifdef SR_MUL_MULHU_EN
  logic            hi_q,    hi_d;
`endif

  // ---------------------------------------------------------------------------
  // Shared partial-product slice
  //   IDLE: live operands, slice 0, no shift (the start-cycle product).
  //   RUN : registered operands, slice 'step', shifted by step*K.
  // ---------------------------------------------------------------------------
  logic [31:0]  sl_a;
  logic [K-1:0] sl_b;
  logic [5:0]   sl_shift;
  logic [W-1:0] sl_pp;
  logic [W-1:0] sum;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    sl_a     = srcA;
    sl_b     = srcB[K-1:0];
    sl_shift = '0;
    if (state_q == RUN) begin
      sl_shift = 6'(int'(step_q) * K);
      sl_a     = a_q;
      sl_b     = K'(b_q >> sl_shift);
    end
  end

  sr_mul_slice #(.K(K)) u_slice (
    .a       (sl_a),
    .b_slice (sl_b),
    .shift   (sl_shift),
    .pp      (sl_pp)
  );

  assign sum = acc_q + sl_pp;

  // ---------------------------------------------------------------------------
  // FSM next state
  //   With N = 1 the whole product is formed in the start cycle, so RUN is
  //   never entered.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (N > 1)) state_d = RUN;
      RUN:     if (step_q == STEP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  //   start is only honoured in IDLE: a start in RUN (including the done
  //   cycle) must not disturb the operation in flight.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    step_d = step_q;
`ifdef SR_MUL_MULHU_EN
    hi_d   = hi_q;
`endif
    if (state_q == IDLE) begin
      if (start) begin
        a_d    = srcA;
        b_d    = srcB;
        acc_d  = sl_pp;
        step_d = SW'(1);
`ifdef SR_MUL_MULHU_EN
        hi_d   = hi;
`endif
      end
    end else if (step_q != STEP_LAST) begin
      acc_d  = sum;
      step_d = step_q + SW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  //   The final partial product is added combinationally in the done cycle
  //   rather than registered, which is what lets the result land in cycle N-1.
  // ---------------------------------------------------------------------------
  logic [W-1:0] done_val;
  logic [31:0]  done_word;

  assign done_val = (state_q == IDLE) ? sl_pp : sum;

`ifdef SR_MUL_MULHU_EN
  // In IDLE only the N = 1 case can complete, and it uses the live 'hi'.
  logic done_hi;
  assign done_hi   = (state_q == IDLE) ? hi : hi_q;
  assign done_word = done_hi ? done_val[63:32] : done_val[31:0];
`else
  assign done_word = done_val;
`endif

  always_comb begin
    busy   = (state_q == RUN);
    done   = 1'b0;
    result = '0;
    if (state_q == IDLE) begin
      if ((N == 1) && start) begin
        done   = 1'b1;
        result = done_word;
      end
    end else if (step_q == STEP_LAST) begin
      done   = 1'b1;
      result = done_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
`ifdef SR_MUL_MULHU_EN
      hi_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
`ifdef SR_MUL_MULHU_EN
      hi_q    <= hi_d;
`endif
    end
  end

endmodule : sr_mul_iter

// File: tb/tb_sr_mul_iter.sv
// -----------------------------------------------------------------------------
// tb_sr_mul_iter
//   Directed bench for sr_mul_iter. One DUT per legal latency
//   (index g -> N = 1 << g) shares clock and reset. Inputs are driven 1 time
//   unit after the rising edge and outputs are sampled on the falling edge.
//   Honors SR_MUL_MULHU_EN (connects 'hi' and runs the MULHU scenario).
// -----------------------------------------------------------------------------
module tb_sr_mul_iter;

  localparam int NG = 6;

  logic          clk;
  logic          rst;
  logic [NG-1:0] start_v;
  logic [NG-1:0] busy_v;
  logic [NG-1:0] done_v;
  logic [NG-1:0] hi_v;
  logic [31:0]   a_v   [NG];
  logic [31:0]   b_v   [NG];
  logic [31:0]   res_v [NG];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < NG; g++) begin : g_dut
    sr_mul_iter #(.N(1 << g)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start_v[g]),
      .srcA   (a_v[g]),
      .srcB   (b_v[g]),
`ifdef SR_MUL_MULHU_EN
      .hi     (hi_v[g]),
`endif
      .busy   (busy_v[g]),
      .done   (done_v[g]),
      .result (res_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one operation on DUT g starting in the current cycle and observes
  // cycles 0..N. Bit c of bm/dm is busy/done seen in cycle c; zm flags a
  // non-zero result while done was low; r is the result seen with done.
  // Operands are scrambled after the start cycle.
  task automatic run_op(input int g, input logic [31:0] a, input logic [31:0] b,
                        input logic h, output logic [63:0] bm,
                        output logic [63:0] dm, output logic zm,
                        output logic [31:0] r);
    int n;
    n  = 1 << g;
    bm = '0;
    dm = '0;
    zm = 1'b0;
    r  = '0;
    a_v[g]     = a;
    b_v[g]     = b;
    hi_v[g]    = h;
    start_v[g] = 1'b1;
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      bm[c] = busy_v[g];
      dm[c] = done_v[g];
      if (done_v[g]) r = res_v[g];
      else if (res_v[g] !== 32'h0) zm = 1'b1;
      @(posedge clk); #1;
      start_v[g] = 1'b0;
      a_v[g]     = ~a;
      b_v[g]     = b + 32'h1357_9BDF;
      hi_v[g]    = ~h;
    end
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    start_v = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy_v !== '0) begin
      n_bad++; $display("FAIL reset_busy: got %b expected %b", busy_v, 6'b0);
    end
    n_cmp++;
    if (done_v !== '0) begin
      n_bad++; $display("FAIL reset_done: got %b expected %b", done_v, 6'b0);
    end
    for (int g = 0; g < NG; g++) begin
      n_cmp++;
      if (res_v[g] !== 32'h0) begin
        n_bad++; $display("FAIL reset_result[%0d]: got %h expected 0", g, res_v[g]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_basic_n4();
    logic [63:0] bm, dm;
    logic        zm;
    logic [31:0] r;
    run_op(2, 32'd7, 32'd6, 1'b0, bm, dm, zm, r);
    n_cmp++;
    if (bm !== 64'h0E) begin
      n_bad++; $display("FAIL n4_busy_mask: got %h expected %h", bm, 64'h0E);
    end
    n_cmp++;
    if (dm !== 64'h08) begin
      n_bad++; $display("FAIL n4_done_mask: got %h expected %h", dm, 64'h08);
    end
    n_cmp++;
    if (r !== 32'd42) begin
      n_bad++; $display("FAIL n4_result: got %0d expected 42", r);
    end
    n_cmp++;
    if (zm !== 1'b0) begin
      n_bad++; $display("FAIL n4_result_idle_zero: got %b expected 0", zm);
    end
  endtask

  task automatic test_wrap_n4();
    logic [63:0] bm, dm;
    logic        zm;
    logic [31:0] r;
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] ve [3];
    va = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
    vb = '{32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0000_0002};
    ve = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFE};
    for (int i = 0; i < 3; i++) begin
      run_op(2, va[i], vb[i], 1'b0, bm, dm, zm, r);
      n_cmp++;
      if (dm !== 64'h08) begin
        n_bad++; $display("FAIL wrap_done_mask[%0d]: got %h expected %h", i, dm, 64'h08);
      end
      n_cmp++;
      if (r !== ve[i]) begin
        n_bad++; $display("FAIL wrap_result[%0d]: got %h expected %h", i, r, ve[i]);
      end
    end
  endtask

  task automatic test_n1();
    logic [63:0] bm, dm;
    logic        zm;
    logic [31:0] r;
    run_op(0, 32'd123, 32'd1000, 1'b0, bm, dm, zm, r);
    n_cmp++;
    if (dm !== 64'h1) begin
      n_bad++; $display("FAIL n1_done_mask: got %h expected %h", dm, 64'h1);
    end
    n_cmp++;
    if (bm !== 64'h0) begin
      n_bad++; $display("FAIL n1_busy_mask: got %h expected 0", bm);
    end
    n_cmp++;
    if (r !== 32'd123000) begin
      n_bad++; $display("FAIL n1_result: got %0d expected 123000", r);
    end
    run_op(0, 32'hFFFF_FFFF, 32'd3, 1'b0, bm, dm, zm, r);
    n_cmp++;
    if (r !== 32'hFFFF_FFFD) begin
      n_bad++; $display("FAIL n1_wrap_result: got %h expected %h", r, 32'hFFFF_FFFD);
    end
  endtask

  task automatic test_n32();
    logic [63:0] bm, dm;
    logic        zm;
    logic [31:0] r;
    run_op(5, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, bm, dm, zm, r);
    n_cmp++;
    if (dm !== 64'h8000_0000) begin
      n_bad++; $display("FAIL n32_done_mask: got %h expected %h", dm, 64'h8000_0000);
    end
    n_cmp++;
    if (bm !== 64'hFFFF_FFFE) begin
      n_bad++; $display("FAIL n32_busy_mask: got %h expected %h", bm, 64'hFFFF_FFFE);
    end
    n_cmp++;
    if (r !== 32'h242D_2080) begin
      n_bad++; $display("FAIL n32_result: got %h expected %h", r, 32'h242D_2080);
    end
  endtask

  // N = 8 with start held high and fresh operands every cycle.
  task automatic test_back_to_back();
    logic [31:0] exp_r;
    int          n_done;
    exp_r  = '0;
    n_done = 0;
    for (int c = 0; c < 26; c++) begin
      start_v[3] = 1'b1;
      a_v[3]     = 32'h0123_4567 + 32'(c) * 32'h0101_0101;
      b_v[3]     = 32'h89AB_CDEF ^ (32'(c) << 5);
      if (c % 8 == 0) exp_r = a_v[3] * b_v[3];
      @(negedge clk);
      n_cmp++;
      if (done_v[3] !== (c % 8 == 7)) begin
        n_bad++; $display("FAIL b2b_done[c%0d]: got %b expected %b", c, done_v[3], (c % 8 == 7));
      end
      if (done_v[3] === 1'b1) begin
        n_done++;
        n_cmp++;
        if (res_v[3] !== exp_r) begin
          n_bad++; $display("FAIL b2b_result[c%0d]: got %h expected %h", c, res_v[3], exp_r);
        end
      end
      @(posedge clk); #1;
    end
    start_v[3] = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (n_done !== 3) begin
      n_bad++; $display("FAIL b2b_done_count: got %0d expected 3", n_done);
    end
  endtask

  // N = 4, reset asserted in cycle 2 of an operation.
  task automatic test_reset_mid();
    logic [63:0] bm, dm;
    logic        zm;
    logic [31:0] r;
    int          n_done;
    n_done     = 0;
    start_v[2] = 1'b1;
    a_v[2]     = 32'd9;
    b_v[2]     = 32'd9;
    @(posedge clk); #1;
    start_v[2] = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (busy_v[2] !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_busy_before: got %b expected 1", busy_v[2]);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (busy_v[2] !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_busy: got %b expected 0", busy_v[2]);
    end
    n_cmp++;
    if (done_v[2] !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_done: got %b expected 0", done_v[2]);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done_v[2] === 1'b1) n_done++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (n_done !== 0) begin
      n_bad++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", n_done);
    end
    run_op(2, 32'd3, 32'd5, 1'b0, bm, dm, zm, r);
    n_cmp++;
    if (dm !== 64'h08) begin
      n_bad++; $display("FAIL rstmid_after_done_mask: got %h expected %h", dm, 64'h08);
    end
    n_cmp++;
    if (r !== 32'd15) begin
      n_bad++; $display("FAIL rstmid_after_result: got %0d expected 15", r);
    end
  endtask

  // Random operands for every latency; the expected product comes from the
  // bench's own 32-bit multiply.
  task automatic test_sweep();
    logic [63:0] bm, dm;
    logic        zm;
    logic [31:0] r, a, b, e;
    int          n;
    for (int g = 0; g < NG; g++) begin
      n = 1 << g;
      for (int i = 0; i < 150; i++) begin
        a = $urandom;
        b = $urandom;
        if (i == 0) a = 32'h0;
        if (i == 1) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
        e = a * b;
        run_op(g, a, b, 1'b0, bm, dm, zm, r);
        n_cmp++;
        if (dm !== (64'd1 << (n - 1))) begin
          n_bad++; $display("FAIL sweep_done_mask[N%0d,%0d]: got %h expected %h", n, i, dm, 64'd1 << (n - 1));
        end
        n_cmp++;
        if (bm !== (((64'd1 << n) - 64'd1) & ~64'd1)) begin
          n_bad++; $display("FAIL sweep_busy_mask[N%0d,%0d]: got %h expected %h", n, i, bm, ((64'd1 << n) - 64'd1) & ~64'd1);
        end
        n_cmp++;
        if (r !== e) begin
          n_bad++; $display("FAIL sweep_result[N%0d,%0d]: %h*%h got %h expected %h", n, i, a, b, r, e);
        end
      end
    end
  endtask

`ifdef SR_MUL_MULHU_EN
  task automatic test_mulhu();
    logic [63:0] bm, dm;
    logic        zm;
    logic [31:0] r;
    run_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, bm, dm, zm, r);
    n_cmp++;
    if (r !== 32'hFFFF_FFFE) begin
      n_bad++; $display("FAIL mulhu_n4_hi: got %h expected %h", r, 32'hFFFF_FFFE);
    end
    run_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, bm, dm, zm, r);
    n_cmp++;
    if (r !== 32'h0000_0001) begin
      n_bad++; $display("FAIL mulhu_n4_lo: got %h expected %h", r, 32'h0000_0001);
    end
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, bm, dm, zm, r);
    n_cmp++;
    if (r !== 32'hFFFF_FFFE) begin
      n_bad++; $display("FAIL mulhu_n1_hi: got %h expected %h", r, 32'hFFFF_FFFE);
    end
  endtask
`endif

  initial begin
    rst     = 1'b0;
    start_v = '0;
    hi_v    = '0;
    for (int i = 0; i < NG; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    test_reset();
    test_basic_n4();
    test_wrap_n4();
    test_n1();
    test_n32();
    test_back_to_back();
    test_reset_mid();
`ifdef SR_MUL_MULHU_EN
    test_mulhu();
`endif
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_sr_mul_iter
